// File: rtl/ps2_key_tracker_if.sv
// Byte stream from the PS/2 receiver into the key tracker, and the tracker's key/display outputs.
interface ps2_key_tracker_if #(
    parameter int CNT_WIDTH = 8
);
    logic [7:0]           ps2dis_data;
    logic                 ps2dis_recFlag;
    logic [7:0]           key_code;
    logic                 key_ext;
    logic                 key_valid;
    logic [CNT_WIDTH-1:0] key_count;
    logic [6:0]           seg0;
    logic [6:0]           seg1;
    logic [6:0]           seg2;
    logic [6:0]           seg3;

    modport master (
        output ps2dis_data, ps2dis_recFlag,
        input  key_code, key_ext, key_valid, key_count, seg0, seg1, seg2, seg3
    );

    modport slave (
        input  ps2dis_data, ps2dis_recFlag,
        output key_code, key_ext, key_valid, key_count, seg0, seg1, seg2, seg3
    );
endinterface

// File: rtl/ps2_key_tracker.sv
// Decodes PS/2 make/break/E0 sequences, filters typematic repeats, counts presses
// and drives four seven-segment digits (scan code low/high, count low/high).
module ps2_key_tracker #(
    parameter int CNT_WIDTH        = 8,
    parameter int CNT_SATURATE     = 0,
    parameter int BLANK_ON_RELEASE = 1,
    parameter int SEG_ACTIVE_LOW   = 1
) (
    input  logic               clk,
    input  logic               rst,
    ps2_key_tracker_if.slave   bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    localparam logic [6:0] SEG_XOR   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam bit         DO_SAT    = (CNT_SATURATE != 0);
    localparam bit         DO_BLANK  = (BLANK_ON_RELEASE != 0);

    logic [1:0]           r_state;
    logic [7:0]           r_code;
    logic                 r_ext;
    logic                 r_valid;
    logic [CNT_WIDTH-1:0] r_count;

    logic [1:0]           w_state_nxt;
    logic                 w_make;
    logic                 w_brk;
    logic                 w_ext;
    logic                 w_match;
    logic [CNT_WIDTH-1:0] w_count_nxt;
    logic [6:0]           w_seg0;
    logic [6:0]           w_seg1;

    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // Prefix sequencer: classifies each strobed byte as prefix, make or break.
    always_comb begin
        w_state_nxt = r_state;
        w_make      = 1'b0;
        w_brk       = 1'b0;
        w_ext       = 1'b0;
        if (bus.ps2dis_recFlag) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.ps2dis_data == 8'hE0) begin
                        w_state_nxt = ST_EXT;
                    end else if (bus.ps2dis_data == 8'hF0) begin
                        w_state_nxt = ST_BRK;
                    end else begin
                        w_make = 1'b1;
                    end
                end
                ST_EXT: begin
                    w_ext = 1'b1;
                    if (bus.ps2dis_data == 8'hF0) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else if (bus.ps2dis_data == 8'hE0) begin
                        w_state_nxt = ST_EXT;
                    end else begin
                        w_make      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    w_brk       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    w_brk       = 1'b1;
                    w_ext       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    assign w_match = r_valid && ({w_ext, bus.ps2dis_data} == {r_ext, r_code});

    // Next press count, wrapping or pinning at all-ones.
    always_comb begin
        if (DO_SAT && (&r_count)) begin
            w_count_nxt = r_count;
        end else begin
            w_count_nxt = r_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Key state registers; a repeated make of the held key is a typematic no-op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_code  <= 8'h00;
            r_ext   <= 1'b0;
            r_valid <= 1'b0;
            r_count <= {CNT_WIDTH{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_make && !w_match) begin
                r_code  <= bus.ps2dis_data;
                r_ext   <= w_ext;
                r_valid <= 1'b1;
                r_count <= w_count_nxt;
            end else if (w_brk && w_match) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Code digits blank while nothing is held when blanking is enabled.
    always_comb begin
        if (DO_BLANK && !r_valid) begin
            w_seg0 = 7'h00;
            w_seg1 = 7'h00;
        end else begin
            w_seg0 = hex_font(r_code[3:0]);
            w_seg1 = hex_font(r_code[7:4]);
        end
    end

    assign bus.key_code  = r_code;
    assign bus.key_ext   = r_ext;
    assign bus.key_valid = r_valid;
    assign bus.key_count = r_count;
    assign bus.seg0      = w_seg0 ^ SEG_XOR;
    assign bus.seg1      = w_seg1 ^ SEG_XOR;
    assign bus.seg2      = hex_font(r_count[3:0]) ^ SEG_XOR;
    assign bus.seg3      = hex_font(r_count[7:4]) ^ SEG_XOR;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench: two trackers (wrap/blank/active-low and saturate/no-blank/active-high) fed the same bytes.
module tb_ps2_key_tracker;
    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       flag;
    int         total;
    int         bad;

    ps2_key_tracker_if #(.CNT_WIDTH(8)) bus_a ();
    ps2_key_tracker_if #(.CNT_WIDTH(8)) bus_b ();

    assign bus_a.ps2dis_data    = data;
    assign bus_a.ps2dis_recFlag = flag;
    assign bus_b.ps2dis_data    = data;
    assign bus_b.ps2dis_recFlag = flag;

    ps2_key_tracker #(.CNT_WIDTH(8), .CNT_SATURATE(0), .BLANK_ON_RELEASE(1), .SEG_ACTIVE_LOW(1))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    ps2_key_tracker #(.CNT_WIDTH(8), .CNT_SATURATE(1), .BLANK_ON_RELEASE(0), .SEG_ACTIVE_LOW(0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the byte is sampled on the next rising edge.
    task automatic send(input logic [7:0] b);
        data = b;
        flag = 1'b1;
        @(negedge clk);
        flag = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        data  = 8'h00;
        flag  = 1'b0;
        rst   = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_code",   {24'd0, bus_a.key_code},  32'h00);
        chk("rst_valid",  {31'd0, bus_a.key_valid}, 32'h0);
        chk("rst_ext",    {31'd0, bus_a.key_ext},   32'h0);
        chk("rst_count",  {24'd0, bus_a.key_count}, 32'h00);
        chk("rst_seg0_a", {25'd0, bus_a.seg0},      32'h7F);
        chk("rst_seg2_a", {25'd0, bus_a.seg2},      32'h40);
        chk("rst_seg3_a", {25'd0, bus_a.seg3},      32'h40);
        chk("rst_seg0_b", {25'd0, bus_b.seg0},      32'h3F);
        chk("rst_seg2_b", {25'd0, bus_b.seg2},      32'h3F);

        send(8'h1C);
        chk("mk_code",    {24'd0, bus_a.key_code},  32'h1C);
        chk("mk_valid",   {31'd0, bus_a.key_valid}, 32'h1);
        chk("mk_count",   {24'd0, bus_a.key_count}, 32'h01);
        chk("mk_seg0_a",  {25'd0, bus_a.seg0},      32'h46);
        chk("mk_seg1_a",  {25'd0, bus_a.seg1},      32'h79);
        chk("mk_seg2_a",  {25'd0, bus_a.seg2},      32'h79);
        chk("mk_seg0_b",  {25'd0, bus_b.seg0},      32'h39);
        chk("mk_seg1_b",  {25'd0, bus_b.seg1},      32'h06);

        send(8'h1C); send(8'h1C); send(8'h1C);
        chk("rep_count",  {24'd0, bus_a.key_count}, 32'h01);
        send(8'hF0); send(8'h1C);
        chk("brk_valid",  {31'd0, bus_a.key_valid}, 32'h0);
        chk("brk_count",  {24'd0, bus_a.key_count}, 32'h01);
        chk("brk_code",   {24'd0, bus_a.key_code},  32'h1C);
        chk("brk_seg0_a", {25'd0, bus_a.seg0},      32'h7F);
        chk("brk_seg1_a", {25'd0, bus_a.seg1},      32'h7F);
        chk("brk_seg0_b", {25'd0, bus_b.seg0},      32'h39);

        send(8'hE0); send(8'h75);
        chk("ext_code",   {24'd0, bus_a.key_code},  32'h75);
        chk("ext_ext",    {31'd0, bus_a.key_ext},   32'h1);
        chk("ext_count",  {24'd0, bus_a.key_count}, 32'h02);
        chk("ext_seg0_a", {25'd0, bus_a.seg0},      32'h12);
        chk("ext_seg1_a", {25'd0, bus_a.seg1},      32'h78);
        send(8'hF0); send(8'h75);
        chk("plainbrk_valid", {31'd0, bus_a.key_valid}, 32'h1);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("extbrk_valid", {31'd0, bus_a.key_valid}, 32'h0);
        chk("extbrk_ext",   {31'd0, bus_a.key_ext},   32'h1);
        chk("extbrk_count", {24'd0, bus_a.key_count}, 32'h02);

        send(8'hE0); send(8'hE0); send(8'h74);
        chk("dupe0_code",  {24'd0, bus_a.key_code},  32'h74);
        chk("dupe0_count", {24'd0, bus_a.key_count}, 32'h03);
        send(8'h74);
        chk("plain74_ext",   {31'd0, bus_a.key_ext},   32'h0);
        chk("plain74_count", {24'd0, bus_a.key_count}, 32'h04);
        send(8'hE0); send(8'hF0); send(8'h74);
        chk("extbrk_other", {31'd0, bus_a.key_valid}, 32'h1);
        send(8'hF0); send(8'h74);
        chk("brk74_valid",  {31'd0, bus_a.key_valid}, 32'h0);

        send(8'h1C); send(8'h32);
        chk("roll_code",  {24'd0, bus_a.key_code},  32'h32);
        chk("roll_count", {24'd0, bus_a.key_count}, 32'h06);
        send(8'hF0); send(8'h1C);
        chk("roll_oldbrk_valid", {31'd0, bus_a.key_valid}, 32'h1);
        chk("roll_oldbrk_code",  {24'd0, bus_a.key_code},  32'h32);
        send(8'hF0); send(8'h32);
        chk("roll_newbrk_valid", {31'd0, bus_a.key_valid}, 32'h0);

        for (int i = 0; i < 249; i++) begin
            send((i % 2 == 1) ? 8'h11 : 8'h10);
        end
        chk("cnt_ff_a", {24'd0, bus_a.key_count}, 32'hFF);
        chk("cnt_ff_b", {24'd0, bus_b.key_count}, 32'hFF);
        send(8'h11);
        chk("cnt_wrap_a", {24'd0, bus_a.key_count}, 32'h00);
        chk("cnt_sat_b",  {24'd0, bus_b.key_count}, 32'hFF);
        chk("cnt_seg2_a", {25'd0, bus_a.seg2},      32'h40);
        chk("cnt_seg3_b", {25'd0, bus_b.seg3},      32'h71);

        send(8'hF0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_count", {24'd0, bus_a.key_count}, 32'h00);
        chk("midrst_valid", {31'd0, bus_a.key_valid}, 32'h0);
        send(8'h1C);
        chk("postrst_count", {24'd0, bus_a.key_count}, 32'h01);
        chk("postrst_valid", {31'd0, bus_a.key_valid}, 32'h1);
        chk("postrst_code",  {24'd0, bus_a.key_code},  32'h1C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
